or1200_pipe_monitor: RTL and testbench

- Synthesizable, parametrised run-time checker for the or1200 control pipeline; the successor to the single-rule delay-slot assertion bound to or1200_ctrl.
- Observes freeze, flush and void vectors for NUM_STAGES stages, delay-slot flags of one chosen stage, and branch/delay-slot retire events.
- Checks four protocol rules, reports violation pulses, sticky flags, saturating per-rule counters, a PC capture and an interrupt.
- Instantiated beside or1200_ctrl in simulation and FPGA debug builds.

---
 rtl/or1200_mon_pkg.sv | 35 +++
 rtl/or1200_sat_cnt.sv | 34 +++
 rtl/or1200_pipe_monitor.sv | 199 +++++++++++++++++++
 tb/tb_or1200_pipe_monitor.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/or1200_mon_pkg.sv
// ----------------------------------------------------------------------------
// or1200_mon_pkg
// Shared definitions for the or1200 pipeline protocol monitor.
//   - Rule index constants, used both as bit positions in the violation
//     vectors and as the encoded value reported in the capture register.
//   - The delay-slot tracking FSM state type.
//   - A helper that picks the lowest-indexed rule out of a hit vector.
// ----------------------------------------------------------------------------
package or1200_mon_pkg;

   localparam int NUM_RULES = 4;

   localparam int R_FREEZE = 0;
   localparam int R_DSLOT  = 1;
   localparam int R_FLUSH  = 2;
   localparam int R_DSTO   = 3;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } ds_state_e;

   // When several rules fire in the same cycle, the capture register reports
   // the lowest-indexed one, so scan from the top down and let lower indices
   // overwrite higher ones.
   function automatic logic [1:0] lowest_rule(input logic [NUM_RULES-1:0] hits);
      lowest_rule = 2'd0;
      for (int r = NUM_RULES - 1; r >= 0; r--) begin
         if (hits[r]) begin
            lowest_rule = 2'(r);
         end
      end
   endfunction

endpackage

// File: rtl/or1200_sat_cnt.sv
// ----------------------------------------------------------------------------
// or1200_sat_cnt
// Saturating event counter used once per monitor rule.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous reset, active-high
//   clr   - synchronous clear; an inc in the same cycle still counts, so the
//           counter lands on 1 rather than 0
//   inc   - count one event this cycle
//   count - current value, sticks at all-ones instead of wrapping
// ----------------------------------------------------------------------------
module or1200_sat_cnt #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   // Clear has priority over the held value but not over a coincident event,
   // so an event arriving with clr is the first one counted after the clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= inc ? WIDTH'(1) : '0;
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/or1200_pipe_monitor.sv
// ----------------------------------------------------------------------------
// or1200_pipe_monitor
// Run-time checker for the or1200 control pipeline. Four protocol rules are
// evaluated every cycle; a rule detected in cycle t is reported in cycle t+1.
//   R0 freeze ordering   : a later stage frozen while the stage before it runs
//   R1 dslot clear       : dsi/nop flags of DS_STAGE must drop one cycle after
//                          an unfrozen dsi && !nop
//   R2 flush propagation : an unfrozen flush of stage i must void stage i in
//                          the following cycle
//   R3 delay-slot FSM    : a taken branch must retire its delay slot within
//                          DS_TIMEOUT cycles, and no branch may sit in a slot
// Ports:
//   clk, rst          - clock (rising edge), asynchronous active-high reset
//   en                - enables checking; low forces trackers idle
//   clr               - synchronous clear of sticky flags, counters, capture
//   stage_freeze/flush/void - per-stage pipeline control vectors
//   ds_dsi, ds_nop    - delay-slot flags of stage DS_STAGE
//   branch_taken      - branch taken in EX
//   ds_retire         - delay-slot instruction leaves EX
//   cur_pc            - PC associated with the detection cycle
//   viol              - one-cycle violation pulse per rule
//   viol_sticky       - sticky per-rule flags
//   viol_cnt          - saturating per-rule counters, rule r at [r*CNT_W +: CNT_W]
//   first_valid/first_rule/first_pc - violation capture register
//   irq               - registered OR of masked sticky flags
// ----------------------------------------------------------------------------
module or1200_pipe_monitor
   import or1200_mon_pkg::*;
#(
   parameter int           NUM_STAGES  = 4,
   parameter int           DS_STAGE    = 2,
   parameter int           DS_TIMEOUT  = 16,
   parameter int           CNT_W       = 8,
   parameter int           LATCH_FIRST = 1,
   parameter logic [3:0]   IRQ_MASK    = 4'b1111
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic                      clr,
   input  logic [NUM_STAGES-1:0]     stage_freeze,
   input  logic [NUM_STAGES-1:0]     stage_flush,
   input  logic [NUM_STAGES-1:0]     stage_void,
   input  logic                      ds_dsi,
   input  logic                      ds_nop,
   input  logic                      branch_taken,
   input  logic                      ds_retire,
   input  logic [31:0]               cur_pc,
   output logic [NUM_RULES-1:0]      viol,
   output logic [NUM_RULES-1:0]      viol_sticky,
   output logic [NUM_RULES*CNT_W-1:0] viol_cnt,
   output logic                      first_valid,
   output logic [1:0]                first_rule,
   output logic [31:0]               first_pc,
   output logic                      irq
);

   localparam logic [7:0] DS_LAST = 8'(DS_TIMEOUT - 1);

   logic [NUM_RULES-1:0]  det;
   logic [NUM_RULES-1:0]  sticky_next;
   logic                  r0_hit;
   logic                  r3_hit;
   logic                  ds_armed;
   logic [NUM_STAGES-1:0] flush_armed;
   ds_state_e             state;
   ds_state_e             state_next;
   logic [7:0]            ds_cnt;
   logic [7:0]            ds_cnt_next;

   // Freeze must spread from the early stages toward the later ones, so any
   // stage frozen while its predecessor keeps moving breaks ordering.
   assign r0_hit = |(stage_freeze[NUM_STAGES-1:1] & ~stage_freeze[NUM_STAGES-2:0]);

   // The R1 and R2 arm flags remember what happened last cycle so the
   // follow-up condition can be checked now; disabling drops them so nothing
   // stale fires when checking resumes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ds_armed    <= 1'b0;
         flush_armed <= '0;
      end else begin
         ds_armed    <= en && !stage_freeze[DS_STAGE] && ds_dsi && !ds_nop;
         flush_armed <= en ? (stage_flush & ~stage_freeze) : '0;
      end
   end

   // Delay-slot tracker state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         ds_cnt <= 8'd0;
      end else begin
         state  <= state_next;
         ds_cnt <= ds_cnt_next;
      end
   end

   // Delay-slot tracker next state. A branch opens the wait window; the slot
   // retiring closes it. A fresh branch inside the window restarts it, and is
   // only legal when the slot retires in that very cycle. The timeout is
   // checked even while frozen, but the count only advances when the stage
   // feeding EX is moving, so stalls do not eat into the budget.
   always_comb begin
      state_next  = state;
      ds_cnt_next = ds_cnt;
      r3_hit      = 1'b0;
      if (!en) begin
         state_next  = IDLE;
         ds_cnt_next = 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (branch_taken) begin
                  state_next  = WAIT;
                  ds_cnt_next = 8'd0;
               end
            end
            WAIT: begin
               if (branch_taken) begin
                  ds_cnt_next = 8'd0;
                  r3_hit      = !ds_retire;
               end else if (ds_retire) begin
                  state_next  = IDLE;
                  ds_cnt_next = 8'd0;
               end else if (ds_cnt == DS_LAST) begin
                  r3_hit      = 1'b1;
                  state_next  = IDLE;
                  ds_cnt_next = 8'd0;
               end else if (!stage_freeze[NUM_STAGES-2]) begin
                  ds_cnt_next = ds_cnt + 8'd1;
               end
            end
            default: begin
               state_next  = IDLE;
               ds_cnt_next = 8'd0;
            end
         endcase
      end
   end

   // Gather this cycle's detections in rule-index order.
   always_comb begin
      det = '0;
      if (en) begin
         det[R_FREEZE] = r0_hit;
         det[R_DSLOT]  = ds_armed && (ds_dsi || ds_nop);
         det[R_FLUSH]  = |(flush_armed & ~stage_void);
         det[R_DSTO]   = r3_hit;
      end
      sticky_next = (clr ? '0 : viol_sticky) | det;
   end

   // Pulse, sticky flags and irq. irq is taken from the updated sticky value
   // so it rises on the same edge as the pulse that caused it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         viol        <= '0;
         viol_sticky <= '0;
         irq         <= 1'b0;
      end else begin
         viol        <= det;
         viol_sticky <= sticky_next;
         irq         <= |(sticky_next & IRQ_MASK);
      end
   end

   // Capture register. A clear empties it, but a detection in the clearing
   // cycle is loaded as if the register were already empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         first_valid <= 1'b0;
         first_rule  <= 2'd0;
         first_pc    <= 32'd0;
      end else if (|det && (clr || (LATCH_FIRST == 0) || !first_valid)) begin
         first_valid <= 1'b1;
         first_rule  <= lowest_rule(det);
         first_pc    <= cur_pc;
      end else if (clr) begin
         first_valid <= 1'b0;
         first_rule  <= 2'd0;
         first_pc    <= 32'd0;
      end
   end

   // One saturating counter per rule.
   for (genvar r = 0; r < NUM_RULES; r++) begin : g_cnt
      or1200_sat_cnt #(
         .WIDTH (CNT_W)
      ) u_cnt (
         .clk   (clk),
         .rst   (rst),
         .clr   (clr),
         .inc   (det[r]),
         .count (viol_cnt[r*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_or1200_pipe_monitor.sv
// ----------------------------------------------------------------------------
// tb_or1200_pipe_monitor
// Directed bench for or1200_pipe_monitor. Two instances share all inputs:
// dut latches the first violation, dut_lf0 tracks the most recent one.
// Expected reports are queued as stimulus is issued; a monitor pops one entry
// every time dut shows a nonzero viol and compares it.
// ----------------------------------------------------------------------------
module tb_or1200_pipe_monitor;
   import or1200_mon_pkg::*;

   localparam int NS = 4;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          clr;
   logic [NS-1:0] stage_freeze;
   logic [NS-1:0] stage_flush;
   logic [NS-1:0] stage_void;
   logic          ds_dsi;
   logic          ds_nop;
   logic          branch_taken;
   logic          ds_retire;
   logic [31:0]   cur_pc;

   logic [3:0]      viol, viol_sticky;
   logic [4*CW-1:0] viol_cnt;
   logic            first_valid, irq;
   logic [1:0]      first_rule;
   logic [31:0]     first_pc;

   logic [3:0]      l_viol, l_sticky;
   logic [4*CW-1:0] l_cnt;
   logic            l_valid, l_irq;
   logic [1:0]      l_rule;
   logic [31:0]     l_pc;

   int cyc = 0;
   int checks = 0;
   int passes = 0;

   typedef struct {
      logic [3:0]  v;
      logic [3:0]  s;
      logic [7:0]  c;
      logic [1:0]  rule;
      int          pcCyc;
      logic [1:0]  lRule;
      int          lPcCyc;
      int          detCyc;
   } exp_t;

   exp_t expQ[$];
   exp_t e;

   or1200_pipe_monitor #(
      .NUM_STAGES (NS), .DS_STAGE (2), .DS_TIMEOUT (4), .CNT_W (CW),
      .LATCH_FIRST (1), .IRQ_MASK (4'b1111)
   ) dut (
      .clk (clk), .rst (rst), .en (en), .clr (clr),
      .stage_freeze (stage_freeze), .stage_flush (stage_flush), .stage_void (stage_void),
      .ds_dsi (ds_dsi), .ds_nop (ds_nop), .branch_taken (branch_taken),
      .ds_retire (ds_retire), .cur_pc (cur_pc),
      .viol (viol), .viol_sticky (viol_sticky), .viol_cnt (viol_cnt),
      .first_valid (first_valid), .first_rule (first_rule), .first_pc (first_pc),
      .irq (irq)
   );

   or1200_pipe_monitor #(
      .NUM_STAGES (NS), .DS_STAGE (2), .DS_TIMEOUT (4), .CNT_W (CW),
      .LATCH_FIRST (0), .IRQ_MASK (4'b1111)
   ) dut_lf0 (
      .clk (clk), .rst (rst), .en (en), .clr (clr),
      .stage_freeze (stage_freeze), .stage_flush (stage_flush), .stage_void (stage_void),
      .ds_dsi (ds_dsi), .ds_nop (ds_nop), .branch_taken (branch_taken),
      .ds_retire (ds_retire), .cur_pc (cur_pc),
      .viol (l_viol), .viol_sticky (l_sticky), .viol_cnt (l_cnt),
      .first_valid (l_valid), .first_rule (l_rule), .first_pc (l_pc),
      .irq (l_irq)
   );

   // Free-running clock and cycle index; cur_pc encodes the cycle so a
   // captured PC identifies exactly which cycle the detection happened in.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] pcOf(input int c);
      return 32'h0000_2000 + 32'(c) * 32'd4;
   endfunction

   assign cur_pc = pcOf(cyc);

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end else begin
         passes++;
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of inputs; they are sampled at the next rising edge.
   task automatic applyStimulus(input logic [3:0] fz, input logic [3:0] fl, input logic [3:0] vd,
                                input logic dsi, input logic nop, input logic br,
                                input logic ret, input logic clr_in);
      stage_freeze = fz;
      stage_flush  = fl;
      stage_void   = vd;
      ds_dsi       = dsi;
      ds_nop       = nop;
      branch_taken = br;
      ds_retire    = ret;
      clr          = clr_in;
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic clearAll;
      applyStimulus(4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic expectViol(input logic [3:0] v, input logic [3:0] s, input logic [7:0] c,
                             input logic [1:0] rule, input int pcCyc,
                             input logic [1:0] lRule, input int lPcCyc, input int detCyc);
      exp_t x;
      x.v = v; x.s = s; x.c = c; x.rule = rule; x.pcCyc = pcCyc;
      x.lRule = lRule; x.lPcCyc = lPcCyc; x.detCyc = detCyc;
      expQ.push_back(x);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_viol"},        64'(viol),        64'd0);
      checkOutput({tag, "_sticky"},      64'(viol_sticky), 64'd0);
      checkOutput({tag, "_cnt"},         64'(viol_cnt),    64'd0);
      checkOutput({tag, "_first_valid"}, 64'(first_valid), 64'd0);
      checkOutput({tag, "_first_rule"},  64'(first_rule),  64'd0);
      checkOutput({tag, "_first_pc"},    64'(first_pc),    64'd0);
      checkOutput({tag, "_irq"},         64'(irq),         64'd0);
   endtask

   // Monitor: every nonzero pulse must match the next queued expectation,
   // including the cycle it was detected in.
   always @(negedge clk) begin
      if (!rst && (viol !== 4'b0)) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_viol", 64'(viol), 64'd0);
         end else begin
            e = expQ.pop_front();
            checkOutput("detect_cycle", 64'(cyc - 1),   64'(e.detCyc));
            checkOutput("viol",         64'(viol),        64'(e.v));
            checkOutput("sticky",       64'(viol_sticky), 64'(e.s));
            checkOutput("cnt",          64'(viol_cnt),    64'(e.c));
            checkOutput("first_valid",  64'(first_valid), 64'd1);
            checkOutput("first_rule",   64'(first_rule),  64'(e.rule));
            checkOutput("first_pc",     64'(first_pc),    64'(pcOf(e.pcCyc)));
            checkOutput("irq",          64'(irq),         64'd1);
            checkOutput("lf0_rule",     64'(l_rule),      64'(e.lRule));
            checkOutput("lf0_pc",       64'(l_pc),        64'(pcOf(e.lPcCyc)));
         end
      end
   end

   int t0;

   initial begin
      rst = 1'b1; en = 1'b1; clr = 1'b0;
      stage_freeze = '0; stage_flush = '0; stage_void = '0;
      ds_dsi = 1'b0; ds_nop = 1'b0; branch_taken = 1'b0; ds_retire = 1'b0;
      tick(); tick();
      checkResetState("reset");
      rst = 1'b0;
      idle(2);

      $display("[TB] R0 freeze ordering");
      t0 = cyc;
      expectViol(4'b0001, 4'b0001, 8'h01, 2'd0, t0, 2'd0, t0, t0);
      applyStimulus(4'b0100, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(2); clearAll(); idle(1);

      $display("[TB] R1 flags held");
      t0 = cyc;
      expectViol(4'b0010, 4'b0010, 8'h04, 2'd1, t0 + 1, 2'd1, t0 + 1, t0 + 1);
      applyStimulus(4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(2); clearAll();

      $display("[TB] R1 flags dropped");
      applyStimulus(4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(3);

      $display("[TB] R2 then R0, capture policy");
      t0 = cyc;
      expectViol(4'b0100, 4'b0100, 8'h10, 2'd2, t0 + 1, 2'd2, t0 + 1, t0 + 1);
      expectViol(4'b0001, 4'b0101, 8'h11, 2'd2, t0 + 1, 2'd0, t0 + 3, t0 + 3);
      applyStimulus(4'b0, 4'b0010, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0100, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(2); clearAll();

      $display("[TB] R2 voided correctly");
      applyStimulus(4'b0, 4'b0010, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0, 4'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(2);

      $display("[TB] R0 and R2 together");
      t0 = cyc;
      expectViol(4'b0101, 4'b0101, 8'h11, 2'd0, t0 + 1, 2'd0, t0 + 1, t0 + 1);
      applyStimulus(4'b0, 4'b0010, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0100, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(2); clearAll();

      $display("[TB] R3 timeout");
      t0 = cyc;
      expectViol(4'b1000, 4'b1000, 8'h40, 2'd3, t0 + 4, 2'd3, t0 + 4, t0 + 4);
      applyStimulus(4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(6); clearAll();

      $display("[TB] R3 retire in time");
      applyStimulus(4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(2);
      applyStimulus(4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(6);

      $display("[TB] R3 branch in delay slot");
      t0 = cyc;
      expectViol(4'b1000, 4'b1000, 8'h40, 2'd3, t0 + 1, 2'd3, t0 + 1, t0 + 1);
      applyStimulus(4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(6); clearAll();

      $display("[TB] R3 branch with retire in WAIT");
      applyStimulus(4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus(4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(6);

      $display("[TB] R3 count held while frozen");
      t0 = cyc;
      expectViol(4'b1000, 4'b1000, 8'h40, 2'd3, t0 + 6, 2'd3, t0 + 6, t0 + 6);
      applyStimulus(4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(4'b1111, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b1111, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(7); clearAll();

      $display("[TB] counter saturation and clear");
      t0 = cyc;
      for (int k = 0; k < 5; k++) begin
         expectViol(4'b0001, 4'b0001, (k < 3) ? 8'(k + 1) : 8'h03, 2'd0, t0, 2'd0, t0 + k, t0 + k);
         applyStimulus(4'b0100, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      expectViol(4'b0001, 4'b0001, 8'h01, 2'd0, t0 + 5, 2'd0, t0 + 5, t0 + 5);
      applyStimulus(4'b0100, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(2); clearAll();

      $display("[TB] disabled checking");
      en = 1'b0;
      applyStimulus(4'b0100, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      en = 1'b1;
      applyStimulus(4'b0, 4'b0010, 4'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      en = 1'b0;
      applyStimulus(4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      en = 1'b1;
      idle(7);
      checkOutput("idle_sticky", 64'(viol_sticky), 64'd0);
      checkOutput("idle_irq",    64'(irq),         64'd0);

      $display("[TB] reset mid-operation");
      t0 = cyc;
      expectViol(4'b0001, 4'b0001, 8'h01, 2'd0, t0, 2'd0, t0, t0);
      applyStimulus(4'b0100, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      stage_freeze = '0;
      #6;
      rst = 1'b1;
      #1;
      checkResetState("midreset");
      tick();
      rst = 1'b0;
      idle(3);

      checkOutput("pending_expectations", 64'(expQ.size()), 64'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
